apple2_kbd_port: RTL

Keyboard responder for the 6502 bus of the Apple II-compatible top level. A host-side producer (PS/2 decoder, UART bridge or bench) hands over 7-bit ASCII key codes through a valid/ready handshake. The codes are buffered in a FIFO and presented to the CPU through the Apple II keyboard latch ($C000 data with bit 7 as strobe, $C010 strobe clear). The top-level address decoder asserts `cs` for the $C000–$C01F page. This block resolves the two registers with `addr[4]`.

---
 rtl/apple2_kbd_port.sv | 97 +++++++++
 1 files changed

// File: rtl/apple2_kbd_port.sv
// Apple II keyboard latch ($C000/$C010) fed by a small FIFO of 7-bit ASCII codes
// pushed by a host through a valid/ready handshake.
module apple2_kbd_port #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_en,
  input  logic          cs,
  input  logic [15:0]   addr,
  input  logic          we,
  output logic [7:0]    data_out,
  input  logic          key_valid,
  input  logic [6:0]    key_data,
  output logic          key_ready,
  input  logic          key_held,
  output logic          strobe,
  output logic [CW-1:0] fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [6:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [6:0]    latch_q;
  logic          strobe_q, strobe_d;
  logic [7:0]    data_out_q, data_out_d;

  logic acc, clr, rd, full, push, pop;
  logic unused_addr;

  assign unused_addr = ^{addr[15:5], addr[3:0]};

  assign acc  = cs & cpu_en;
  assign clr  = acc & addr[4];
  assign rd   = acc & ~we;
  assign full = (count_q == CW'(DEPTH));
  assign push = key_valid & ~full;
  // A strobe clear blocks the load for one edge so the CPU always sees the flag drop.
  assign pop  = ~strobe_q & (count_q != '0) & ~clr;

  assign key_ready  = ~full;
  assign strobe     = strobe_q;
  assign data_out   = data_out_q;
  assign fifo_count = count_q;

  always_comb begin
    count_d    = count_q;
    strobe_d   = strobe_q;
    data_out_d = data_out_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (clr) begin
      strobe_d = 1'b0;
    end else if (pop) begin
      strobe_d = 1'b1;
    end
    // $C010 reads report the physical key state instead of the strobe.
    if (rd) begin
      data_out_d = addr[4] ? {key_held, latch_q} : {strobe_q, latch_q};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= key_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      latch_q    <= 7'h00;
      strobe_q   <= 1'b0;
      data_out_q <= 8'h00;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        latch_q  <= mem_q[rd_ptr_q];
      end
      count_q    <= count_d;
      strobe_q   <= strobe_d;
      data_out_q <= data_out_d;
    end
  end

endmodule
